// File: rtl/sha256_iter_core.sv
// sha256_iter_core -- iterative SHA-256 compression core, UNROLL rounds per clock.
//
// One 512-bit chunk is accepted per transaction; the chaining value is either the
// standard SHA-256 IV (in_init=1) or in_hash. The result is held on out_hash until
// the downstream handshake completes.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in_vld   : chunk / in_hash / in_init valid
//   in_rdy   : core idle and able to accept a chunk
//   in_init  : 1 selects the SHA-256 IV, 0 selects in_hash
//   chunk    : message block, [511:480]=W0 ... [31:0]=W15
//   in_hash  : chaining value, [255:224]=H0 ... [31:0]=H7
//   out_vld  : out_hash valid
//   out_rdy  : downstream accepts out_hash
//   out_hash : chunk result, same word order as in_hash
//   busy     : high whenever the core is not idle
module sha256_iter_core #(
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic         in_init,
    input  logic [511:0] chunk,
    input  logic [255:0] in_hash,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [255:0] out_hash,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
        $error("sha256_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t       state_q;
    logic [6:0]   cnt_q;
    logic         out_vld_q;
    logic [255:0] out_hash_q;
    logic [31:0]  wv_q    [8];   // working variables a..h at index 0..7
    logic [31:0]  wv_d    [8];
    logic [31:0]  w_q     [16];  // schedule window, index 0 holds W[cnt]
    logic [31:0]  w_d     [16];
    logic [31:0]  saved_q [8];   // chaining value added back in ADD

    // UNROLL rounds chained combinationally. The window always shifts and always
    // computes W[t+16]; words produced past round 63 are simply never consumed.
    always_comb begin
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] wn;
        logic [5:0]  kidx;
        wv_d = wv_q;
        w_d  = w_q;
        t1   = '0;
        t2   = '0;
        wn   = '0;
        kidx = '0;
        for (int unsigned u = 0; u < UNROLL; u++) begin
            kidx = cnt_q[5:0] + 6'(u);
            t1 = wv_d[7] + bsig1(wv_d[4]) + ((wv_d[4] & wv_d[5]) ^ (~wv_d[4] & wv_d[6]))
               + K[kidx] + w_d[0];
            t2 = bsig0(wv_d[0]) + ((wv_d[0] & wv_d[1]) ^ (wv_d[0] & wv_d[2]) ^ (wv_d[1] & wv_d[2]));
            wv_d[7] = wv_d[6];
            wv_d[6] = wv_d[5];
            wv_d[5] = wv_d[4];
            wv_d[4] = wv_d[3] + t1;
            wv_d[3] = wv_d[2];
            wv_d[2] = wv_d[1];
            wv_d[1] = wv_d[0];
            wv_d[0] = t1 + t2;
            wn = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
            for (int unsigned j = 0; j < 15; j++) begin
                w_d[j] = w_d[j + 1];
            end
            w_d[15] = wn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_hash_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                wv_q[i]    <= '0;
                saved_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        for (int unsigned i = 0; i < 16; i++) begin
                            w_q[i] <= chunk[511 - 32 * i -: 32];
                        end
                        for (int unsigned i = 0; i < 8; i++) begin
                            saved_q[i] <= in_init ? IV[255 - 32 * i -: 32] : in_hash[255 - 32 * i -: 32];
                            wv_q[i]    <= in_init ? IV[255 - 32 * i -: 32] : in_hash[255 - 32 * i -: 32];
                        end
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    wv_q  <= wv_d;
                    w_q   <= w_d;
                    cnt_q <= cnt_q + 7'(UNROLL);
                    if (cnt_q + 7'(UNROLL) == 7'd64) begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        out_hash_q[255 - 32 * i -: 32] <= saved_q[i] + wv_q[i];
                    end
                    out_vld_q <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rdy   = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign out_vld  = out_vld_q;
    assign out_hash = out_hash_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: three instances (UNROLL 1, 4, 16) exercised in turn
// through a shared stimulus bus and a per-instance handshake select.
module tb_sha256_iter_core;

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_MSG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] C_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] C_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] C_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] C_M2    = {480'h0, 32'h000001c0};

    typedef struct packed {
        logic [511:0] chunk;
        logic         init;
        logic [255:0] hash;
        logic         chain;   // use previous result as in_hash
        logic         chk;     // compare digest
        logic [255:0] exp;
        int unsigned  hold;    // cycles of out_rdy=0 once out_vld is up
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_init;
    logic [511:0] chunk;
    logic [255:0] in_hash;
    logic [2:0]   in_vld_v;
    logic [2:0]   out_rdy_v;
    logic [2:0]   in_rdy_v;
    logic [2:0]   out_vld_v;
    logic [2:0]   busy_v;
    logic [255:0] oh0, oh1, oh2;

    int unsigned  sel;
    int unsigned  ucur;
    logic         c_in_rdy, c_out_vld, c_busy;
    logic [255:0] c_out_hash;

    int checks = 0;
    int errors = 0;
    logic [255:0] sb_q [$];

    always #5 clk = ~clk;

    sha256_iter_core #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld_v[0]), .in_rdy(in_rdy_v[0]), .in_init(in_init),
        .chunk(chunk), .in_hash(in_hash), .out_vld(out_vld_v[0]), .out_rdy(out_rdy_v[0]),
        .out_hash(oh0), .busy(busy_v[0])
    );
    sha256_iter_core #(.UNROLL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld_v[1]), .in_rdy(in_rdy_v[1]), .in_init(in_init),
        .chunk(chunk), .in_hash(in_hash), .out_vld(out_vld_v[1]), .out_rdy(out_rdy_v[1]),
        .out_hash(oh1), .busy(busy_v[1])
    );
    sha256_iter_core #(.UNROLL(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld_v[2]), .in_rdy(in_rdy_v[2]), .in_init(in_init),
        .chunk(chunk), .in_hash(in_hash), .out_vld(out_vld_v[2]), .out_rdy(out_rdy_v[2]),
        .out_hash(oh2), .busy(busy_v[2])
    );

    always_comb begin
        c_in_rdy  = in_rdy_v[sel];
        c_out_vld = out_vld_v[sel];
        c_busy    = busy_v[sel];
        case (sel)
            0:       c_out_hash = oh0;
            1:       c_out_hash = oh1;
            default: c_out_hash = oh2;
        endcase
    end

    task automatic chk_w(input string nm, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (UNROLL=%0d): got %h expected %h", nm, ucur, got, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s (UNROLL=%0d): got %0d expected %0d", nm, ucur, got, exp);
        end
    endtask

    // Called at a negedge with the selected instance idle; returns at a negedge.
    task automatic run_txn(input logic [511:0] ch, input logic init, input logic [255:0] hv,
                           input logic do_chk, input logic [255:0] exp, input int unsigned hold,
                           output logic [255:0] got);
        int unsigned lat;
        logic [255:0] e;
        chk_i("in_rdy before accept", int'(c_in_rdy), 1);
        chunk   = ch;
        in_init = init;
        in_hash = hv;
        in_vld_v[sel]  = 1'b1;
        out_rdy_v[sel] = (hold == 0);
        if (do_chk) sb_q.push_back(exp);
        @(posedge clk);
        #1;
        in_vld_v[sel] = 1'b0;
        chunk   = {16{$urandom}};
        in_hash = {8{$urandom}};
        in_init = 1'($urandom_range(0, 1));
        chk_i("busy after accept", int'(c_busy), 1);
        lat = 0;
        while (!c_out_vld && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = c_out_hash;
        if (!c_out_vld) begin
            chk_i("out_vld timeout", 0, 1);
            @(negedge clk);
            return;
        end
        chk_i("latency edges", int'(lat), int'(64 / ucur + 1));
        if (do_chk) begin
            if (sb_q.size() == 0) begin
                chk_i("scoreboard empty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk_w("digest", c_out_hash, e);
            end
        end
        if (hold > 0) begin
            in_vld_v[sel] = 1'b1;       // must be ignored outside IDLE
            chunk = C_EMPTY;
            for (int unsigned k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                chk_i("hold out_vld", int'(c_out_vld), 1);
                chk_i("hold in_rdy", int'(c_in_rdy), 0);
                if (do_chk) chk_w("hold out_hash", c_out_hash, exp);
            end
            in_vld_v[sel]  = 1'b0;
            out_rdy_v[sel] = 1'b1;
        end
        @(posedge clk);                 // output handshake edge
        #1;
        chk_i("out_vld after handshake", int'(c_out_vld), 0);
        chk_i("in_rdy after handshake", int'(c_in_rdy), 1);
        chk_i("busy after handshake", int'(c_busy), 0);
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        int unsigned pulses;
        chk_i("in_rdy before accept", int'(c_in_rdy), 1);
        chunk   = C_ABC;
        in_init = 1'b1;
        in_vld_v[sel]  = 1'b1;
        out_rdy_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_vld_v[sel] = 1'b0;
        repeat (32 / ucur) @(posedge clk);   // round counter now at 32
        #2;
        chk_i("busy mid-run", int'(c_busy), 1);
        rst_n = 1'b0;
        #1;
        chk_i("out_vld in reset", int'(c_out_vld), 0);
        chk_i("in_rdy in reset", int'(c_in_rdy), 1);
        chk_w("out_hash in reset", c_out_hash, '0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            if (c_out_vld) pulses++;
        end
        chk_i("out_vld pulses after reset", int'(pulses), 0);
        chk_i("in_rdy after reset", int'(c_in_rdy), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [7];
        logic [255:0] prev;
        logic [255:0] hv;

        vt[0] = '{chunk: C_ABC,   init: 1'b1, hash: {8{32'hdeadbeef}}, chain: 1'b0, chk: 1'b1, exp: D_ABC,   hold: 0};
        vt[1] = '{chunk: C_EMPTY, init: 1'b1, hash: '1,                 chain: 1'b0, chk: 1'b1, exp: D_EMPTY, hold: 0};
        vt[2] = '{chunk: C_M1,    init: 1'b1, hash: '0,                 chain: 1'b0, chk: 1'b0, exp: '0,      hold: 0};
        vt[3] = '{chunk: C_M2,    init: 1'b0, hash: '0,                 chain: 1'b1, chk: 1'b1, exp: D_MSG,   hold: 0};
        vt[4] = '{chunk: C_ABC,   init: 1'b0, hash: IV,                 chain: 1'b0, chk: 1'b1, exp: D_ABC,   hold: 0};
        vt[5] = '{chunk: C_ABC,   init: 1'b1, hash: '0,                 chain: 1'b0, chk: 1'b1, exp: D_ABC,   hold: 20};
        vt[6] = '{chunk: C_EMPTY, init: 1'b1, hash: '0,                 chain: 1'b0, chk: 1'b1, exp: D_EMPTY, hold: 0};

        rst_n     = 1'b0;
        in_vld_v  = '0;
        out_rdy_v = '0;
        in_init   = 1'b0;
        chunk     = '0;
        in_hash   = '0;
        sel       = 0;
        ucur      = 1;
        prev      = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel  = s;
            ucur = (s == 0) ? 1 : ((s == 1) ? 4 : 16);
            #0;
            chk_i("reset out_vld", int'(c_out_vld), 0);
            chk_i("reset busy", int'(c_busy), 0);
            chk_w("reset out_hash", c_out_hash, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            sel  = s;
            ucur = (s == 0) ? 1 : ((s == 1) ? 4 : 16);
            #0;
            chk_i("in_rdy after reset release", int'(c_in_rdy), 1);
            for (int i = 0; i < 7; i++) begin
                hv = vt[i].chain ? prev : vt[i].hash;
                run_txn(vt[i].chunk, vt[i].init, hv, vt[i].chk, vt[i].exp, vt[i].hold, prev);
            end
            reset_mid_run();
            run_txn(C_ABC, 1'b1, '0, 1'b1, D_ABC, 0, prev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
